// File: rtl/maxpool_stream_if.sv
// maxpool_stream_if: control, sample and pooled-result signals of the max-pool stage.
// master drives frame start and samples; slave is the pooling engine.
interface maxpool_stream_if #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned IN_W      = 8,
  parameter int unsigned IN_H      = 8,
  parameter int unsigned CHANNELS  = 16
);
  localparam int unsigned OROW_W = (IN_H / 2 > 1) ? $clog2(IN_H / 2) : 1;
  localparam int unsigned OCOL_W = (IN_W / 2 > 1) ? $clog2(IN_W / 2) : 1;
  localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                        pool_en;
  logic                        in_valid;
  logic signed [DATA_SIZE-1:0] in_data;
  logic                        out_valid;
  logic signed [DATA_SIZE-1:0] out_data;
  logic [OROW_W-1:0]           out_row;
  logic [OCOL_W-1:0]           out_col;
  logic [CH_W-1:0]             out_ch;
  logic                        busy;
  logic                        pool_finish;

  modport master (
    output pool_en, in_valid, in_data,
    input  out_valid, out_data, out_row, out_col, out_ch, busy, pool_finish
  );

  modport slave (
    input  pool_en, in_valid, in_data,
    output out_valid, out_data, out_row, out_col, out_ch, busy, pool_finish
  );
endinterface

// File: rtl/maxpool_stream.sv
// maxpool_stream: 2x2 stride-2 signed max pooling over a channel-major raster stream.
// Define MAXPOOL_RELU_EN to clamp negative input samples to zero before pooling.
module maxpool_stream #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned IN_W      = 8,
  parameter int unsigned IN_H      = 8,
  parameter int unsigned CHANNELS  = 16
) (
  input logic             clk,
  input logic             rst,
  maxpool_stream_if.slave bus
);
  localparam int unsigned COL_CW   = $clog2(IN_W);
  localparam int unsigned ROW_CW   = $clog2(IN_H);
  localparam int unsigned CH_CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned OROW_W   = (IN_H / 2 > 1) ? $clog2(IN_H / 2) : 1;
  localparam int unsigned OCOL_W   = (IN_W / 2 > 1) ? $clog2(IN_W / 2) : 1;
  localparam int unsigned LB_DEPTH = IN_W / 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [COL_CW-1:0] col;
  logic [ROW_CW-1:0] row;
  logic [CH_CW-1:0]  ch;

  logic accept_c, start_c, complete_c, last_c;
  logic col_last_c, row_last_c, ch_last_c;
  logic [OCOL_W-1:0] lb_idx_c;

  logic signed [DATA_SIZE-1:0] x_c, hold, pair_max_c, lb_rd_c, result_c;
  logic signed [DATA_SIZE-1:0] linebuf [LB_DEPTH];

  // Position decode for the sample on the bus this cycle
  always_comb begin
    accept_c   = (state == RUN) && bus.in_valid;
    start_c    = (state == IDLE) && bus.pool_en;
    col_last_c = (col == COL_CW'(IN_W - 1));
    row_last_c = (row == ROW_CW'(IN_H - 1));
    ch_last_c  = (ch == CH_CW'(CHANNELS - 1));
    complete_c = accept_c && col[0] && row[0];
    last_c     = accept_c && col_last_c && row_last_c && ch_last_c;
    lb_idx_c   = OCOL_W'(col >> 1);
  end

`ifdef MAXPOOL_RELU_EN
  assign x_c = bus.in_data[DATA_SIZE-1] ? '0 : bus.in_data;
`else
  assign x_c = bus.in_data;
`endif

  // Horizontal pair max, then vertical max against the stored even-row pair
  assign pair_max_c = (x_c > hold) ? x_c : hold;
  assign lb_rd_c    = linebuf[lb_idx_c];
  assign result_c   = (lb_rd_c > pair_max_c) ? lb_rd_c : pair_max_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.pool_en) state_nxt = RUN;
      RUN:     if (last_c)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Raster position counters: col -> row -> channel
  always_ff @(posedge clk) begin
    if (rst || start_c) begin
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else if (accept_c) begin
      if (col_last_c) begin
        col <= '0;
        if (row_last_c) begin
          row <= '0;
          ch  <= ch_last_c ? '0 : ch + CH_CW'(1);
        end else begin
          row <= row + ROW_CW'(1);
        end
      end else begin
        col <= col + COL_CW'(1);
      end
    end
  end

  // Pooling storage is fully rewritten before use in every frame, so it carries no reset
  always_ff @(posedge clk) begin
    if (accept_c && !col[0]) begin
      hold <= x_c;
    end
    if (accept_c && col[0] && !row[0]) begin
      linebuf[lb_idx_c] <= pair_max_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_row     <= '0;
      bus.out_col     <= '0;
      bus.out_ch      <= '0;
      bus.busy        <= 1'b0;
      bus.pool_finish <= 1'b0;
    end else begin
      bus.out_valid   <= complete_c;
      bus.pool_finish <= last_c;
      bus.busy        <= (state_nxt == RUN);
      if (complete_c) begin
        bus.out_data <= result_c;
        bus.out_row  <= OROW_W'(row >> 1);
        bus.out_col  <= lb_idx_c;
        bus.out_ch   <= ch;
      end
    end
  end
endmodule

// File: tb/tb_maxpool_stream.sv
// tb_maxpool_stream: three configurations of maxpool_stream against a behavioural pooling model.
// Expected results come from plain 2x2 window maxima over the frame the driver sends.
module tb_maxpool_stream;
  localparam int unsigned DW = 16;

  typedef struct {
    int data;
    int row;
    int col;
    int ch;
    bit fin;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maxpool_stream_if #(.DATA_SIZE(DW), .IN_W(4), .IN_H(4), .CHANNELS(1)) if_a ();
  maxpool_stream_if #(.DATA_SIZE(DW), .IN_W(4), .IN_H(4), .CHANNELS(2)) if_b ();
  maxpool_stream_if #(.DATA_SIZE(DW), .IN_W(2), .IN_H(2), .CHANNELS(1)) if_c ();

  maxpool_stream #(.DATA_SIZE(DW), .IN_W(4), .IN_H(4), .CHANNELS(1))
    u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  maxpool_stream #(.DATA_SIZE(DW), .IN_W(4), .IN_H(4), .CHANNELS(2))
    u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  maxpool_stream #(.DATA_SIZE(DW), .IN_W(2), .IN_H(2), .CHANNELS(1))
    u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  int n_checks = 0;
  int n_fail   = 0;
  exp_t qa[$], qb[$], qc[$];
  int seen_a[$], seen_b[$], seen_b_ch[$], seen_c[$];
  int fin_cnt [3];
  int frame_buf [0:63];
  string nm [3] = '{"a", "b", "c"};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dim(input int w);
    return (w == 2) ? 2 : 4;
  endfunction

  function automatic int nch(input int w);
    return (w == 1) ? 2 : 1;
  endfunction

  function automatic int relu(input int x);
`ifdef MAXPOOL_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic int rnd16();
    case ($urandom_range(0, 9))
      0:       return -32768;
      1:       return 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  function automatic int q_size(input int w);
    case (w)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic q_push(input int w, input exp_t e);
    case (w)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  task automatic q_pop(input int w, output exp_t e);
    case (w)
      0:       e = qa.pop_front();
      1:       e = qb.pop_front();
      default: e = qc.pop_front();
    endcase
  endtask

  // Reference: each pooled value is the max of its 2x2 window, emitted channel/row/col order
  task automatic push_frame(input int w);
    exp_t e;
    int d, nc, m, v;
    d  = dim(w);
    nc = nch(w);
    for (int ci = 0; ci < nc; ci++)
      for (int pr = 0; pr < d / 2; pr++)
        for (int pc = 0; pc < d / 2; pc++) begin
          m = relu(frame_buf[ci * d * d + 2 * pr * d + 2 * pc]);
          for (int k = 1; k < 4; k++) begin
            v = relu(frame_buf[ci * d * d + (2 * pr + k / 2) * d + 2 * pc + k % 2]);
            if (v > m) m = v;
          end
          e.data = m;
          e.row  = pr;
          e.col  = pc;
          e.ch   = ci;
          e.fin  = (ci == nc - 1) && (pr == d / 2 - 1) && (pc == d / 2 - 1);
          q_push(w, e);
        end
  endtask

  task automatic drv(input int w, input logic en, input logic v, input int d);
    case (w)
      0: begin if_a.pool_en = en; if_a.in_valid = v; if_a.in_data = DW'(d); end
      1: begin if_b.pool_en = en; if_b.in_valid = v; if_b.in_data = DW'(d); end
      default: begin if_c.pool_en = en; if_c.in_valid = v; if_c.in_data = DW'(d); end
    endcase
  endtask

  function automatic logic busy_of(input int w);
    case (w)
      0:       return if_a.busy;
      1:       return if_b.busy;
      default: return if_c.busy;
    endcase
  endfunction

  task automatic mon(input int w, input logic v, input logic signed [DW-1:0] d,
                     input int r, input int c, input int ch, input logic fin);
    exp_t e;
    if (v === 1'b1) begin
      if (q_size(w) == 0) begin
        chk($sformatf("%s_spurious_out_valid", nm[w]), 1, 0);
      end else begin
        q_pop(w, e);
        chk($sformatf("%s_out_data", nm[w]), int'(d), e.data);
        chk($sformatf("%s_out_row", nm[w]), r, e.row);
        chk($sformatf("%s_out_col", nm[w]), c, e.col);
        chk($sformatf("%s_out_ch", nm[w]), ch, e.ch);
        chk($sformatf("%s_pool_finish", nm[w]), int'(fin), int'(e.fin));
        case (w)
          0: seen_a.push_back(int'(d));
          1: begin seen_b.push_back(int'(d)); seen_b_ch.push_back(ch); end
          default: seen_c.push_back(int'(d));
        endcase
      end
      if (fin === 1'b1) fin_cnt[w]++;
    end else if (fin === 1'b1) begin
      chk($sformatf("%s_finish_without_valid", nm[w]), 1, 0);
      fin_cnt[w]++;
    end
  endtask

  always @(negedge clk) begin
    mon(0, if_a.out_valid, if_a.out_data, int'(if_a.out_row), int'(if_a.out_col),
        int'(if_a.out_ch), if_a.pool_finish);
    mon(1, if_b.out_valid, if_b.out_data, int'(if_b.out_row), int'(if_b.out_col),
        int'(if_b.out_ch), if_b.pool_finish);
    mon(2, if_c.out_valid, if_c.out_data, int'(if_c.out_row), int'(if_c.out_col),
        int'(if_c.out_ch), if_c.pool_finish);
  end

  // gap_mode: 0 none, 1 every third cycle idle, 2 random idles; abort_at<0 runs to the end
  task automatic run_frame(input int w, input int gap_mode, input bit keep_en,
                           input int abort_at, input bit poke);
    int n, cyc;
    n   = dim(w) * dim(w) * nch(w);
    cyc = 0;
    push_frame(w);
    drv(w, 1'b1, 1'b0, 0);
    @(negedge clk);
    chk($sformatf("%s_busy_rise", nm[w]), int'(busy_of(w)), 1);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        drv(w, 1'b0, 1'b0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        qa.delete();
        qb.delete();
        qc.delete();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      while ((gap_mode == 1 && cyc % 3 == 2) || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
        drv(w, keep_en, 1'b0, rnd16());
        cyc++;
        @(negedge clk);
      end
      drv(w, keep_en || (poke && i == n / 2), 1'b1, frame_buf[i]);
      cyc++;
      @(negedge clk);
    end
    drv(w, keep_en, 1'b0, 0);
    chk($sformatf("%s_busy_fall", nm[w]), int'(busy_of(w)), 0);
  endtask

  task automatic settle(input int w);
    repeat (2) @(negedge clk);
    #1;
    chk($sformatf("%s_pending_outputs", nm[w]), q_size(w), 0);
  endtask

  task automatic clear_seen();
    seen_a.delete();
    seen_b.delete();
    seen_b_ch.delete();
    seen_c.delete();
    for (int k = 0; k < 3; k++) fin_cnt[k] = 0;
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_out_valid"}, int'(if_a.out_valid), 0);
    chk({tag, "_out_data"}, int'(if_a.out_data), 0);
    chk({tag, "_out_row"}, int'(if_a.out_row), 0);
    chk({tag, "_out_col"}, int'(if_a.out_col), 0);
    chk({tag, "_out_ch"}, int'(if_a.out_ch), 0);
    chk({tag, "_busy"}, int'(if_a.busy), 0);
    chk({tag, "_pool_finish"}, int'(if_a.pool_finish), 0);
  endtask

  initial begin
    int lit0 [4];
    int lit1 [4];
    int neg_exp;
    lit0 = '{5, 7, 13, 15};
    lit1 = '{105, 107, 113, 115};
`ifdef MAXPOOL_RELU_EN
    neg_exp = 0;
`else
    neg_exp = -3;
`endif

    rst = 1'b1;
    for (int w = 0; w < 3; w++) drv(w, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);
    check_reset_a("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single-channel 4x4 ramp
    for (int i = 0; i < 16; i++) frame_buf[i] = i;
    clear_seen();
    run_frame(0, 0, 1'b0, -1, 1'b0);
    settle(0);
    chk("ramp_count", seen_a.size(), 4);
    for (int k = 0; k < seen_a.size() && k < 4; k++) chk($sformatf("ramp_val%0d", k), seen_a[k], lit0[k]);
    chk("ramp_finish_count", fin_cnt[0], 1);

    // Negative samples on a 2x2 plane
    frame_buf[0] = -9; frame_buf[1] = -3; frame_buf[2] = -7; frame_buf[3] = -5;
    clear_seen();
    run_frame(2, 0, 1'b0, -1, 1'b0);
    settle(2);
    chk("neg_count", seen_c.size(), 1);
    if (seen_c.size() > 0) chk("neg_val", seen_c[0], neg_exp);

    // Two channels with every third cycle idle
    for (int i = 0; i < 16; i++) begin
      frame_buf[i]      = i;
      frame_buf[16 + i] = 100 + i;
    end
    clear_seen();
    run_frame(1, 1, 1'b0, -1, 1'b0);
    settle(1);
    chk("mc_count", seen_b.size(), 8);
    for (int k = 0; k < 4 && 4 + k < seen_b.size(); k++) begin
      chk($sformatf("mc_ch0_val%0d", k), seen_b[k], lit0[k]);
      chk($sformatf("mc_ch1_val%0d", k), seen_b[4 + k], lit1[k]);
      chk($sformatf("mc_ch1_ch%0d", k), seen_b_ch[4 + k], 1);
    end
    chk("mc_finish_count", fin_cnt[1], 1);

    // Abort after seven samples, then ignored IDLE samples, then a fresh frame
    for (int i = 0; i < 16; i++) frame_buf[i] = i;
    run_frame(0, 0, 1'b0, 7, 1'b0);
    check_reset_a("abort");
    for (int k = 0; k < 3; k++) begin
      drv(0, 1'b0, 1'b1, 99);
      @(negedge clk);
      chk("idle_busy", int'(if_a.busy), 0);
    end
    drv(0, 1'b0, 1'b0, 0);
    clear_seen();
    run_frame(0, 0, 1'b0, -1, 1'b1);
    settle(0);
    chk("fresh_count", seen_a.size(), 4);
    for (int k = 0; k < seen_a.size() && k < 4; k++) chk($sformatf("fresh_val%0d", k), seen_a[k], lit0[k]);
    chk("fresh_finish_count", fin_cnt[0], 1);

    // Back-to-back frames with pool_en held high
    clear_seen();
    for (int i = 0; i < 16; i++) frame_buf[i] = rnd16();
    run_frame(0, 0, 1'b1, -1, 1'b0);
    for (int i = 0; i < 16; i++) frame_buf[i] = rnd16();
    run_frame(0, 0, 1'b0, -1, 1'b0);
    settle(0);
    chk("b2b_count", seen_a.size(), 8);
    chk("b2b_finish_count", fin_cnt[0], 2);

    // Randomized frames with random gaps and ignored pool_en pulses
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 32; i++) frame_buf[i] = rnd16();
      run_frame(0, 2, 1'b0, -1, 1'b1);
      settle(0);
      run_frame(1, 2, 1'b0, -1, 1'b1);
      settle(1);
      run_frame(2, 2, 1'b0, -1, 1'b0);
      settle(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end
endmodule
